// File: rtl/sram_arbiter_if.sv
// Bundle of signals between the SRAM arbiter, its two requesters
// (AHB front end on port A, AES round engine on port B) and the SRAM.
// The slave modport is the arbiter's view; the master modport is the
// view of the side that drives requests and returns SRAM read data.
interface sram_arbiter_if;
   // Port A requester
   logic         a_req;
   logic         a_we;
   logic [15:0]  a_addr;
   logic [127:0] a_wdata;
   logic         a_gnt;
   logic         a_ack;
   logic         a_err;
   logic [127:0] a_rdata;

   // Port B requester
   logic         b_req;
   logic         b_we;
   logic [15:0]  b_addr;
   logic [127:0] b_wdata;
   logic         b_gnt;
   logic         b_ack;
   logic         b_err;
   logic [127:0] b_rdata;

   // SRAM side
   logic         sram_read;
   logic         sram_write;
   logic [15:0]  sram_addr;
   logic [127:0] sram_wdata;
   logic [127:0] sram_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_ack, a_err, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_ack, b_err, b_rdata,
      output sram_read, sram_write, sram_addr, sram_wdata,
      input  sram_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_ack, a_err, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_ack, b_err, b_rdata,
      input  sram_read, sram_write, sram_addr, sram_wdata,
      output sram_rdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port 128-bit SRAM between two
// requesters. Each access runs SETUP -> ACCESS (-> CAPTURE for reads)
// -> DONE; out-of-range addresses go straight to ERR without touching
// the SRAM. Every output is a flop loaded from the next-state decode.
module sram_arbiter #(
   parameter logic [15:0] ADDR_LIMIT = 16'd64
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERR     = 3'd5
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Transaction state and the request latched at arbitration.
   state_t        state_r;
   state_t        state_s;
   logic          last_winner_r;
   logic          last_winner_s;
   logic          win_r;
   logic          win_s;
   logic          we_r;
   logic          we_s;
   logic [15:0]   addr_r;
   logic [15:0]   addr_s;
   logic [127:0]  wdata_r;
   logic [127:0]  wdata_s;

   // Output decode of the next state and its registered copy.
   logic          gnt_any_s;
   logic          ack_any_s;
   logic          err_any_s;
   logic          a_gnt_s, a_ack_s, a_err_s;
   logic          b_gnt_s, b_ack_s, b_err_s;
   logic          sram_read_s, sram_write_s;
   logic [15:0]   sram_addr_s;
   logic [127:0]  sram_wdata_s;

   logic          a_gnt_r, a_ack_r, a_err_r;
   logic          b_gnt_r, b_ack_r, b_err_r;
   logic          sram_read_r, sram_write_r;
   logic [15:0]   sram_addr_r;
   logic [127:0]  sram_wdata_r;
   logic [127:0]  a_rdata_r;
   logic [127:0]  b_rdata_r;

   // Next-state logic: arbitrate and latch the winner's request in IDLE, then step the access phases.
   always_comb begin
      state_s       = state_r;
      last_winner_s = last_winner_r;
      win_s         = win_r;
      we_s          = we_r;
      addr_s        = addr_r;
      wdata_s       = wdata_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.a_req || bus.b_req) begin
               // On a tie the port that did not win last time goes next.
               if (bus.a_req && bus.b_req) begin
                  win_s = ~last_winner_r;
               end else if (bus.b_req) begin
                  win_s = PORT_B;
               end else begin
                  win_s = PORT_A;
               end
               last_winner_s = win_s;
               if (win_s == PORT_B) begin
                  we_s    = bus.b_we;
                  addr_s  = bus.b_addr;
                  wdata_s = bus.b_wdata;
               end else begin
                  we_s    = bus.a_we;
                  addr_s  = bus.a_addr;
                  wdata_s = bus.a_wdata;
               end
               if (addr_s >= ADDR_LIMIT) begin
                  state_s = ST_ERR;
               end else begin
                  state_s = ST_SETUP;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP:   state_s = ST_ACCESS;
         ST_ACCESS: begin
            if (we_r) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_CAPTURE;
            end
         end
         ST_CAPTURE: state_s = ST_DONE;
         ST_DONE:    state_s = ST_IDLE;
         ST_ERR:     state_s = ST_IDLE;
         default:    state_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state so every output can be taken straight from a flop.
   always_comb begin
      gnt_any_s    = 1'b0;
      ack_any_s    = 1'b0;
      err_any_s    = 1'b0;
      sram_read_s  = 1'b0;
      sram_write_s = 1'b0;
      sram_addr_s  = 16'd0;
      sram_wdata_s = 128'd0;
      case (state_s)
         ST_IDLE: begin
            gnt_any_s = 1'b0;
         end
         ST_SETUP: begin
            gnt_any_s    = 1'b1;
            sram_addr_s  = addr_s;
            sram_wdata_s = we_s ? wdata_s : 128'd0;
         end
         ST_ACCESS: begin
            gnt_any_s    = 1'b1;
            sram_addr_s  = addr_s;
            sram_wdata_s = we_s ? wdata_s : 128'd0;
            sram_write_s = we_s;
            sram_read_s  = ~we_s;
         end
         ST_CAPTURE: begin
            gnt_any_s   = 1'b1;
            sram_addr_s = addr_s;
         end
         ST_DONE: begin
            gnt_any_s = 1'b1;
            ack_any_s = 1'b1;
         end
         ST_ERR: begin
            gnt_any_s = 1'b1;
            ack_any_s = 1'b1;
            err_any_s = 1'b1;
         end
         default: begin
            gnt_any_s = 1'b0;
         end
      endcase
      a_gnt_s = gnt_any_s & (win_s == PORT_A);
      a_ack_s = ack_any_s & (win_s == PORT_A);
      a_err_s = err_any_s & (win_s == PORT_A);
      b_gnt_s = gnt_any_s & (win_s == PORT_B);
      b_ack_s = ack_any_s & (win_s == PORT_B);
      b_err_s = err_any_s & (win_s == PORT_B);
   end

   // State, arbitration history and latched request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         last_winner_r <= PORT_B;
         win_r         <= PORT_A;
         we_r          <= 1'b0;
         addr_r        <= 16'd0;
         wdata_r       <= 128'd0;
      end else begin
         state_r       <= state_s;
         last_winner_r <= last_winner_s;
         win_r         <= win_s;
         we_r          <= we_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
      end
   end

   // Registered handshake and SRAM control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_gnt_r      <= 1'b0;
         a_ack_r      <= 1'b0;
         a_err_r      <= 1'b0;
         b_gnt_r      <= 1'b0;
         b_ack_r      <= 1'b0;
         b_err_r      <= 1'b0;
         sram_read_r  <= 1'b0;
         sram_write_r <= 1'b0;
         sram_addr_r  <= 16'd0;
         sram_wdata_r <= 128'd0;
      end else begin
         a_gnt_r      <= a_gnt_s;
         a_ack_r      <= a_ack_s;
         a_err_r      <= a_err_s;
         b_gnt_r      <= b_gnt_s;
         b_ack_r      <= b_ack_s;
         b_err_r      <= b_err_s;
         sram_read_r  <= sram_read_s;
         sram_write_r <= sram_write_s;
         sram_addr_r  <= sram_addr_s;
         sram_wdata_r <= sram_wdata_s;
      end
   end

   // Capture SRAM read data into the winning port's result register during CAPTURE only.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_rdata_r <= 128'd0;
         b_rdata_r <= 128'd0;
      end else if (state_r == ST_CAPTURE) begin
         if (win_r == PORT_B) begin
            b_rdata_r <= bus.sram_rdata;
         end else begin
            a_rdata_r <= bus.sram_rdata;
         end
      end
   end

   assign bus.a_gnt      = a_gnt_r;
   assign bus.a_ack      = a_ack_r;
   assign bus.a_err      = a_err_r;
   assign bus.a_rdata    = a_rdata_r;
   assign bus.b_gnt      = b_gnt_r;
   assign bus.b_ack      = b_ack_r;
   assign bus.b_err      = b_err_r;
   assign bus.b_rdata    = b_rdata_r;
   assign bus.sram_read  = sram_read_r;
   assign bus.sram_write = sram_write_r;
   assign bus.sram_addr  = sram_addr_r;
   assign bus.sram_wdata = sram_wdata_r;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port 128-bit test SRAM between two requesters: the AHB slave front end (port A) and the AES round engine (port B). Each SRAM access is sequenced as setup, strobe and capture phases. Arbitration is round-robin, and out-of-range addresses are rejected with an error acknowledge. The block sits between both requesters and the SRAM model and owns every SRAM control line.

## Interface
- ADDR_LIMIT, 64: first illegal word address; requests with addr >= ADDR_LIMIT are rejected.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req, b_req  in  1  request; held high until the matching ack.
- a_we, b_we  in  1  1 = write, 0 = read; valid while req is high.
- a_addr, b_addr  in  16  word address.
- a_wdata, b_wdata  in  128  write data.
- a_gnt, b_gnt  out  1  high from the SETUP state through DONE/ERR of that port's transaction.
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_err, b_err  out  1  one-cycle pulse, coincident with ack, on a rejected request.
- a_rdata, b_rdata  out  128  registered read result; holds until that port's next successful read.
- sram_read, sram_write  out  1  SRAM strobes.
- sram_addr  out  16  SRAM address.
- sram_wdata  out  128  SRAM write data.
- sram_rdata  in  128  SRAM read data; valid the cycle after sram_read.

## Operation
- States:
  - IDLE: no strobes; all SRAM outputs 0.
  - SETUP: sram_addr and sram_wdata (writes only) driven from the latched request; strobes 0.
  - ACCESS: same address and data as SETUP; sram_write = we, sram_read = !we.
  - CAPTURE: sram_addr held; sram_rdata is registered into the winner's rdata at the end of this cycle.
  - DONE: winner's ack = 1; SRAM outputs 0.
  - ERR: winner's ack = 1 and err = 1; the SRAM is never touched.
- Transitions:
  - IDLE with no req: stay in IDLE.
  - IDLE with any req: choose a winner, latch its we/addr/wdata, then go to ERR if addr >= ADDR_LIMIT, else to SETUP.
  - SETUP goes to ACCESS.
  - ACCESS goes to CAPTURE for a read, or to DONE for a write.
  - CAPTURE goes to DONE.
  - DONE goes to IDLE.
  - ERR goes to IDLE.
  - Any other encoding goes to IDLE.
- Arbitration happens only in IDLE:
  - With one request, that port wins.
  - With both requesting, the port opposite to last_winner wins.
  - last_winner updates on every arbitration, including ones that end in ERR.
  - last_winner resets to B, so A wins the first tie.
- Latched fields are frozen for the whole transaction. A requester changing addr/wdata mid-transaction has no effect.
- A req still high in the DONE/ERR cycle is treated as a new request in the following IDLE cycle. Requesters must drop req on the cycle after ack.
- Dropping req before ack is illegal. The transaction still completes and acks.
- Write data never passes through rdata. rdata changes only in CAPTURE and only for the winning port.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from req to gnt.
- Reset values: state IDLE, last_winner B, every gnt/ack/err 0, sram_read/sram_write 0, sram_addr 0, sram_wdata 0, a_rdata/b_rdata 0.
- Write: req is sampled in IDLE at edge 0. Edges 1, 2 and 3 enter SETUP, ACCESS and DONE. ack is seen in cycle 3, so req-to-ack latency is 3 cycles.
- Read: SETUP, ACCESS, CAPTURE, DONE. ack comes 4 cycles after the request is sampled, and rdata is valid in the ack cycle.
- Reject: ack and err come 1 cycle after the request is sampled.
- Back-to-back: minimum IDLE-to-IDLE period is 5 cycles for a read and 4 for a write. Under contention both ports alternate strictly, so the wait is bounded by one transaction of the other port plus one IDLE cycle.
- rst asserted mid-transaction (any state): everything returns to reset values at the next edge. No ack is issued and the latched request is discarded. A strobe already asserted drops at that edge.

## Test plan
- Reset, then a_req write with addr 0x0000 and wdata 0x00112233…EEFF: SETUP shows sram_addr 0 with the data. ACCESS has sram_write = 1 for exactly one cycle. a_ack arrives 3 cycles after the request with a_err 0.
- Port B reads addr 0x0020 from an SRAM preloaded with 0xDEADBEEF…: sram_read = 1 for one cycle. b_rdata equals the preload when b_ack pulses, 4 cycles after the request, and a_rdata is unchanged.
- a_req and b_req rise together after reset: A is served first. B receives b_gnt in the IDLE+1 cycle after a_ack. A second simultaneous pair is served B then A.
- a_req with addr 0x0040 (ADDR_LIMIT 64): a_ack and a_err pulse 1 cycle after the request. sram_read/sram_write stay 0, and the next tie goes to B.
- rst asserted during ACCESS of a write: sram_write is 0 on the next edge and no ack is issued. All outputs match reset values, and a fresh request then completes normally.
- A changes a_addr from 0x0010 to 0x0030 during SETUP: sram_addr stays 0x0010 through ACCESS.
